inst_encoder_loader: RTL

- Instruction-memory loader that converts decoded instruction descriptors into 32-bit MIPS-subset machine words.
- Writes the words sequentially into instruction memory; it is the encode direction of the core's instruction decoder.
- Sits between a host/boot sequencer (valid/ready stream) and the imem write port. Used to load programs before the core is released from halt.

---
 rtl/inst_encoder_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_encoder_loader.sv
// Instruction-memory loader: encodes decoded MIPS-subset descriptors into 32-bit
// machine words and writes them sequentially into instruction memory.
module inst_encoder_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLT  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_J    = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic                we_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [31:0]         wdata_next;
  logic [ADDR_W:0]     count_next;
  logic                overflow_next;
  logic                accept;

  // Only the fields each format uses are packed; anything else on the inputs is dropped.
  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [25:0] imm
  );
    logic [31:0] word;
    word = 32'h0;
    case (op)
      OP_ADD:  word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      OP_SLT:  word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      OP_LW:   word = {6'h23, rs, rt, imm[15:0]};
      OP_SW:   word = {6'h2B, rs, rt, imm[15:0]};
      OP_ADDI: word = {6'h08, rs, rt, imm[15:0]};
      OP_BEQ:  word = {6'h04, rs, rt, imm[15:0]};
      OP_J:    word = {6'h02, imm};
      OP_HALT: word = 32'hFC00_0000;
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign accept   = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      imem_we    <= we_next;
      imem_addr  <= addr_next;
      imem_wdata <= wdata_next;
      word_count <= count_next;
      overflow   <= overflow_next;
    end
  end

  // The word is registered at the accepting edge, so done and the final write
  // appear together in the following cycle; the pointer stops at the last address.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    we_next       = 1'b0;
    addr_next     = imem_addr;
    wdata_next    = imem_wdata;
    count_next    = word_count;
    overflow_next = overflow;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next    = RUN;
          ptr_next      = BASE;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = ptr;
          wdata_next = encode(in_op, in_rs, in_rt, in_rd, in_imm);
          count_next = word_count + 1'b1;
          if (in_op == OP_HALT) begin
            state_next = DONE;
          end else if (ptr == LAST_ADDR) begin
            state_next    = DONE;
            overflow_next = 1'b1;
          end else begin
            ptr_next = ptr + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
